// File: rtl/altera_tse_gxb_aligned_rxsync_mc_pkg.sv
// Shared definitions for the GXB receive-side sync aligner.
// Holds the special code-group values, the per-channel word record that
// travels down the alignment pipeline, the idle word forced onto unsynced
// outputs, and the carrier-detect next-value rule.
package altera_tse_gxb_aligned_rxsync_mc_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;  // comma
   localparam logic [7:0] K27_7 = 8'hFB;  // start-of-packet /S/

   // One channel's decoded byte plus its status flags.
   typedef struct packed {
      logic       sync;
      logic [7:0] data;
      logic       ctrl;
      logic       err;
      logic       disp;
      logic       del;
      logic       ins;
   } rx_word_t;

   // Idle field values presented while a word is not synced.
   localparam logic [7:0] IDLE_DATA = 8'h00;
   localparam logic       IDLE_CTRL = 1'b0;
   localparam logic       IDLE_ERR  = 1'b1;
   localparam logic       IDLE_DISP = 1'b1;
   localparam logic       IDLE_RMF  = 1'b0;

   localparam rx_word_t IDLE_WORD = '{sync: 1'b0, data: IDLE_DATA, ctrl: IDLE_CTRL,
                                      err: IDLE_ERR, disp: IDLE_DISP,
                                      del: IDLE_RMF, ins: IDLE_RMF};

   // Carrier rule applied to the word currently on the output side.
   // Losing sync always reports carrier; a comma ends it; /S/ or a
   // code-group error (false carrier) starts it; anything else holds.
   function automatic logic carrier_next(input rx_word_t w, input logic cur);
      logic nxt;
      nxt = cur;
      if (!w.sync)                         nxt = 1'b1;
      else if (w.ctrl && w.data == K28_5)  nxt = 1'b0;
      else if (w.ctrl && w.data == K27_7)  nxt = 1'b1;
      else if (w.err)                      nxt = 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/altera_tse_gxb_aligned_rxsync_mc_if.sv
// Bundle of the GXB-side (alt_*) inputs and the aligned (altpcs_*) outputs
// for NUM_CH channels; channel c owns bit c, or byte [8c+7:8c] of the data.
//   master : the GXB/consumer side, drives alt_*, receives altpcs_*
//   slave  : the aligner, receives alt_*, drives altpcs_*
// Stream semantics: there is no valid/ready pair. Every clk edge carries
// exactly one word per channel in each direction and neither side can stall
// the other; altpcs_sync is the only qualifier of an output word.
interface altera_tse_gxb_aligned_rxsync_mc_if #(
   parameter int NUM_CH = 1
);
   logic [8*NUM_CH-1:0] alt_dataout;
   logic [NUM_CH-1:0]   alt_sync;
   logic [NUM_CH-1:0]   alt_ctrldetect;
   logic [NUM_CH-1:0]   alt_errdetect;
   logic [NUM_CH-1:0]   alt_disperr;
   logic [NUM_CH-1:0]   alt_patterndetect;
   logic [NUM_CH-1:0]   alt_rmfifodatadeleted;
   logic [NUM_CH-1:0]   alt_rmfifodatainserted;

   logic [8*NUM_CH-1:0] altpcs_dataout;
   logic [NUM_CH-1:0]   altpcs_sync;
   logic [NUM_CH-1:0]   altpcs_ctrldetect;
   logic [NUM_CH-1:0]   altpcs_errdetect;
   logic [NUM_CH-1:0]   altpcs_disperr;
   logic [NUM_CH-1:0]   altpcs_rmfifodatadeleted;
   logic [NUM_CH-1:0]   altpcs_rmfifodatainserted;
   logic [NUM_CH-1:0]   altpcs_carrierdetect;

   modport master (
      output alt_dataout, alt_sync, alt_ctrldetect, alt_errdetect, alt_disperr,
             alt_patterndetect, alt_rmfifodatadeleted, alt_rmfifodatainserted,
      input  altpcs_dataout, altpcs_sync, altpcs_ctrldetect, altpcs_errdetect,
             altpcs_disperr, altpcs_rmfifodatadeleted, altpcs_rmfifodatainserted,
             altpcs_carrierdetect
   );

   modport slave (
      input  alt_dataout, alt_sync, alt_ctrldetect, alt_errdetect, alt_disperr,
             alt_patterndetect, alt_rmfifodatadeleted, alt_rmfifodatainserted,
      output altpcs_dataout, altpcs_sync, altpcs_ctrldetect, altpcs_errdetect,
             altpcs_disperr, altpcs_rmfifodatadeleted, altpcs_rmfifodatainserted,
             altpcs_carrierdetect
   );
endinterface

// File: rtl/altera_tse_gxb_rxsync_lane.sv
// One receive channel: sync debounce, PIPE_DEPTH-stage alignment pipeline,
// optional idle masking of unsynced words, saturating error counter and
// registered carrier detect.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   in_word          GXB word; in_word.sync is the raw alt_sync
//   err_cnt_clr      synchronous counter clear (wins over increment)
//   out_word         aligned word; out_word.sync is the qualified sync
//   carrierdetect    carrier status, one cycle behind out_word
//   err_cnt          saturating count of errored synced output words
module altera_tse_gxb_rxsync_lane
   import altera_tse_gxb_aligned_rxsync_mc_pkg::*;
#(
   parameter int PIPE_DEPTH    = 2,
   parameter int SYNC_DEBOUNCE = 4,
   parameter int ERR_CNT_W     = 16,
   parameter int MASK_UNSYNCED = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  rx_word_t             in_word,
   input  logic                 err_cnt_clr,
   output rx_word_t             out_word,
   output logic                 carrierdetect,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [7:0] DB_MAX = 8'(SYNC_DEBOUNCE);
   localparam bit         MASK   = (MASK_UNSYNCED != 0);

   logic [7:0] db_cnt;
   logic       qual_sync;
   rx_word_t   stage_word;
   rx_word_t   pipe_q [PIPE_DEPTH];
   rx_word_t   tail;
   logic       err_hit;

   // Qualification uses the counter value before this cycle's increment,
   // so SYNC_DEBOUNCE=0 qualifies on the first high cycle and any low
   // cycle disqualifies immediately.
   assign qual_sync = in_word.sync && (db_cnt == DB_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)             db_cnt <= 8'd0;
      else if (!in_word.sync)   db_cnt <= 8'd0;
      else if (db_cnt != DB_MAX) db_cnt <= db_cnt + 8'd1;
   end

   always_comb begin
      stage_word      = in_word;
      stage_word.sync = qual_sync;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PIPE_DEPTH; i++) pipe_q[i] <= IDLE_WORD;
      end else begin
         pipe_q[0] <= stage_word;
         for (int i = 1; i < PIPE_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tail     = pipe_q[PIPE_DEPTH-1];
   assign out_word = (MASK && !tail.sync) ? IDLE_WORD : tail;

   // Counter and carrier both look at the word as presented on the output.
   assign err_hit = out_word.sync && (out_word.err || out_word.disp);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 err_cnt <= '0;
      else if (err_cnt_clr)         err_cnt <= '0;
      else if (err_hit && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) carrierdetect <= 1'b1;
      else          carrierdetect <= carrier_next(out_word, carrierdetect);
   end

endmodule

// File: rtl/altera_tse_gxb_aligned_rxsync_mc.sv
// Multi-channel GXB receive sync aligner. Each of NUM_CH channels is an
// independent altera_tse_gxb_rxsync_lane; this level only slices the
// interface vectors per channel.
// Ports:
//   clk, reset_n   single clock, asynchronous active-low reset
//   rx             alt_* inputs / altpcs_* aligned outputs (slave side);
//                  its NUM_CH must match this module's NUM_CH
//   err_cnt_clr    per-channel synchronous error counter clear
//   err_cnt        per-channel saturating error count, ERR_CNT_W bits each
// alt_patterndetect is carried on the interface for pin compatibility but
// has no function in the aligner.
module altera_tse_gxb_aligned_rxsync_mc
   import altera_tse_gxb_aligned_rxsync_mc_pkg::*;
#(
   parameter int NUM_CH        = 1,
   parameter int PIPE_DEPTH    = 2,
   parameter int SYNC_DEBOUNCE = 4,
   parameter int ERR_CNT_W     = 16,
   parameter int MASK_UNSYNCED = 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   altera_tse_gxb_aligned_rxsync_mc_if.slave rx,
   input  logic [NUM_CH-1:0]           err_cnt_clr,
   output logic [ERR_CNT_W*NUM_CH-1:0] err_cnt
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      rx_word_t in_w;
      rx_word_t out_w;

      always_comb begin
         in_w      = '0;
         in_w.sync = rx.alt_sync[c];
         in_w.data = rx.alt_dataout[8*c +: 8];
         in_w.ctrl = rx.alt_ctrldetect[c];
         in_w.err  = rx.alt_errdetect[c];
         in_w.disp = rx.alt_disperr[c];
         in_w.del  = rx.alt_rmfifodatadeleted[c];
         in_w.ins  = rx.alt_rmfifodatainserted[c];
      end

      altera_tse_gxb_rxsync_lane #(
         .PIPE_DEPTH    (PIPE_DEPTH),
         .SYNC_DEBOUNCE (SYNC_DEBOUNCE),
         .ERR_CNT_W     (ERR_CNT_W),
         .MASK_UNSYNCED (MASK_UNSYNCED)
      ) u_lane (
         .clk           (clk),
         .reset_n       (reset_n),
         .in_word       (in_w),
         .err_cnt_clr   (err_cnt_clr[c]),
         .out_word      (out_w),
         .carrierdetect (rx.altpcs_carrierdetect[c]),
         .err_cnt       (err_cnt[ERR_CNT_W*c +: ERR_CNT_W])
      );

      assign rx.altpcs_sync[c]               = out_w.sync;
      assign rx.altpcs_dataout[8*c +: 8]     = out_w.data;
      assign rx.altpcs_ctrldetect[c]         = out_w.ctrl;
      assign rx.altpcs_errdetect[c]          = out_w.err;
      assign rx.altpcs_disperr[c]            = out_w.disp;
      assign rx.altpcs_rmfifodatadeleted[c]  = out_w.del;
      assign rx.altpcs_rmfifodatainserted[c] = out_w.ins;
   end

endmodule

// File: tb/tb_altera_tse_gxb_aligned_rxsync_mc.sv
// Bench for the GXB sync aligner. Two instances share clock and reset:
//   dut_a : NUM_CH=2, PIPE_DEPTH=2, SYNC_DEBOUNCE=4, ERR_CNT_W=8, masked
//   dut_b : NUM_CH=1, PIPE_DEPTH=2, SYNC_DEBOUNCE=4, ERR_CNT_W=8, unmasked
// Lanes 0/1 are dut_a channels 0/1, lane 2 is dut_b channel 0.
module tb_altera_tse_gxb_aligned_rxsync_mc;
   import altera_tse_gxb_aligned_rxsync_mc_pkg::*;

   localparam int P = 2;
   localparam int D = 4;
   localparam int NL = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus variables ----------------
   logic [7:0] d_data [NL];
   logic       d_sync [NL];
   logic       d_ctrl [NL];
   logic       d_err  [NL];
   logic       d_disp [NL];
   logic       d_del  [NL];
   logic       d_ins  [NL];
   logic       d_clr  [NL];

   altera_tse_gxb_aligned_rxsync_mc_if #(.NUM_CH(2)) ifa ();
   altera_tse_gxb_aligned_rxsync_mc_if #(.NUM_CH(1)) ifb ();
   logic [15:0] err_cnt_a;
   logic [7:0]  err_cnt_b;

   assign ifa.alt_dataout            = {d_data[1], d_data[0]};
   assign ifa.alt_sync               = {d_sync[1], d_sync[0]};
   assign ifa.alt_ctrldetect         = {d_ctrl[1], d_ctrl[0]};
   assign ifa.alt_errdetect          = {d_err[1],  d_err[0]};
   assign ifa.alt_disperr            = {d_disp[1], d_disp[0]};
   assign ifa.alt_patterndetect      = {d_ctrl[1], d_ctrl[0]};
   assign ifa.alt_rmfifodatadeleted  = {d_del[1],  d_del[0]};
   assign ifa.alt_rmfifodatainserted = {d_ins[1],  d_ins[0]};

   assign ifb.alt_dataout            = d_data[2];
   assign ifb.alt_sync               = d_sync[2];
   assign ifb.alt_ctrldetect         = d_ctrl[2];
   assign ifb.alt_errdetect          = d_err[2];
   assign ifb.alt_disperr            = d_disp[2];
   assign ifb.alt_patterndetect      = d_ctrl[2];
   assign ifb.alt_rmfifodatadeleted  = d_del[2];
   assign ifb.alt_rmfifodatainserted = d_ins[2];

   altera_tse_gxb_aligned_rxsync_mc #(
      .NUM_CH(2), .PIPE_DEPTH(P), .SYNC_DEBOUNCE(D), .ERR_CNT_W(8), .MASK_UNSYNCED(1)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .rx(ifa.slave),
      .err_cnt_clr({d_clr[1], d_clr[0]}), .err_cnt(err_cnt_a)
   );

   altera_tse_gxb_aligned_rxsync_mc #(
      .NUM_CH(1), .PIPE_DEPTH(P), .SYNC_DEBOUNCE(D), .ERR_CNT_W(8), .MASK_UNSYNCED(0)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .rx(ifb.slave),
      .err_cnt_clr(d_clr[2]), .err_cnt(err_cnt_b)
   );

   // ---------------- counters ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- behavioural model ----------------
   // Each lane keeps the last P accepted words; the output is the oldest of
   // them. A word is synced when alt_sync was high for at least D cycles in
   // a row before it and is high now.
   rx_word_t   hist [NL][$];
   int         run_len [NL];
   logic [7:0] m_err [NL];
   logic       m_car [NL];

   function automatic rx_word_t idle_w();
      rx_word_t w;
      w = '0;
      w.err  = 1'b1;
      w.disp = 1'b1;
      return w;
   endfunction

   function automatic rx_word_t model_out(input int l);
      rx_word_t w;
      if (hist[l].size() < P) return idle_w();
      w = hist[l][0];
      if (l < 2 && !w.sync) return idle_w();
      return w;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      rx_word_t cur, nw;
      for (int l = 0; l < NL; l++) begin
         if (!reset_n) begin
            hist[l].delete();
            run_len[l] = 0;
            m_err[l]   = 8'd0;
            m_car[l]   = 1'b1;
         end else begin
            cur = model_out(l);
            if (d_clr[l])                                          m_err[l] = 8'd0;
            else if (cur.sync && (cur.err || cur.disp) && m_err[l] != 8'd255) m_err[l] = m_err[l] + 8'd1;
            if (!cur.sync)                          m_car[l] = 1'b1;
            else if (cur.ctrl && cur.data == 8'hBC) m_car[l] = 1'b0;
            else if (cur.ctrl && cur.data == 8'hFB) m_car[l] = 1'b1;
            else if (cur.err)                       m_car[l] = 1'b1;
            nw.sync = d_sync[l] && (run_len[l] >= D);
            nw.data = d_data[l];
            nw.ctrl = d_ctrl[l];
            nw.err  = d_err[l];
            nw.disp = d_disp[l];
            nw.del  = d_del[l];
            nw.ins  = d_ins[l];
            run_len[l] = d_sync[l] ? ((run_len[l] < 1000) ? run_len[l] + 1 : run_len[l]) : 0;
            hist[l].push_back(nw);
            if (hist[l].size() > P) void'(hist[l].pop_front());
         end
      end
   end

   // ---------------- DUT observation ----------------
   function automatic rx_word_t get_act(input int l);
      rx_word_t w;
      if (l < 2) begin
         w.sync = ifa.altpcs_sync[l];
         w.data = ifa.altpcs_dataout[8*l +: 8];
         w.ctrl = ifa.altpcs_ctrldetect[l];
         w.err  = ifa.altpcs_errdetect[l];
         w.disp = ifa.altpcs_disperr[l];
         w.del  = ifa.altpcs_rmfifodatadeleted[l];
         w.ins  = ifa.altpcs_rmfifodatainserted[l];
      end else begin
         w.sync = ifb.altpcs_sync[0];
         w.data = ifb.altpcs_dataout;
         w.ctrl = ifb.altpcs_ctrldetect[0];
         w.err  = ifb.altpcs_errdetect[0];
         w.disp = ifb.altpcs_disperr[0];
         w.del  = ifb.altpcs_rmfifodatadeleted[0];
         w.ins  = ifb.altpcs_rmfifodatainserted[0];
      end
      return w;
   endfunction

   function automatic logic act_car(input int l);
      return (l < 2) ? ifa.altpcs_carrierdetect[l] : ifb.altpcs_carrierdetect[0];
   endfunction

   function automatic logic [7:0] act_err(input int l);
      return (l == 0) ? err_cnt_a[7:0] : (l == 1) ? err_cnt_a[15:8] : err_cnt_b;
   endfunction

   // ---------------- scoreboard compare (every cycle) ----------------
   always @(negedge clk) begin
      rx_word_t ew, aw;
      for (int l = 0; l < NL; l++) begin
         ew = model_out(l);
         aw = get_act(l);
         n_cmp++;
         if (aw !== ew) begin
            n_fail++;
            $display("FAIL word lane%0d t=%0t: got %h expected %h", l, $time, aw, ew);
         end
         n_cmp++;
         if (act_car(l) !== m_car[l]) begin
            n_fail++;
            $display("FAIL carrier lane%0d t=%0t: got %b expected %b", l, $time, act_car(l), m_car[l]);
         end
         n_cmp++;
         if (act_err(l) !== m_err[l]) begin
            n_fail++;
            $display("FAIL err_cnt lane%0d t=%0t: got %h expected %h", l, $time, act_err(l), m_err[l]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_lane(input int l, input logic s, input logic [7:0] d, input logic k,
                           input logic e, input logic dp, input logic dl, input logic in);
      d_sync[l] = s;  d_data[l] = d;  d_ctrl[l] = k;
      d_err[l]  = e;  d_disp[l] = dp; d_del[l]  = dl; d_ins[l] = in;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      for (int l = 0; l < NL; l++) begin
         set_lane(l, 0, 8'h00, 0, 0, 0, 0, 0);
         d_clr[l] = 1'b0;
      end
      tick(3);
      check("rst_sync_a",   32'(ifa.altpcs_sync), 32'h0);
      check("rst_data_a",   32'(ifa.altpcs_dataout), 32'h0);
      check("rst_errdet_a", 32'(ifa.altpcs_errdetect), 32'h3);
      check("rst_disp_a",   32'(ifa.altpcs_disperr), 32'h3);
      check("rst_car_a",    32'(ifa.altpcs_carrierdetect), 32'h3);
      check("rst_errcnt_a", 32'(err_cnt_a), 32'h0);
      reset_n = 1'b1;                                   // cycle 0
      tick(10);                                         // cycle 10
      set_lane(0, 1, 8'h50, 0, 0, 0, 0, 0);
      set_lane(2, 0, 8'h5A, 0, 0, 0, 0, 0);
      tick(2);                                          // cycle 12
      check("nomask_data_b",   32'(ifb.altpcs_dataout), 32'h5A);
      check("nomask_sync_b",   32'(ifb.altpcs_sync), 32'h0);
      check("nomask_errcnt_b", 32'(err_cnt_b), 32'h0);
      tick(3);                                          // cycle 15
      check("qual_early", 32'(ifa.altpcs_sync[0]), 32'h0);
      tick(1);                                          // cycle 16
      check("qual_first", 32'(ifa.altpcs_sync[0]), 32'h1);
      check("ch1_quiet",  32'(ifa.altpcs_sync[1]), 32'h0);
      check("qual_data",  32'(ifa.altpcs_dataout[7:0]), 32'h50);
      set_lane(0, 0, 8'h50, 0, 0, 0, 0, 0);             // one-cycle drop
      tick(1);                                          // cycle 17
      check("drop_lag", 32'(ifa.altpcs_sync[0]), 32'h1);
      set_lane(0, 1, 8'h50, 0, 0, 0, 0, 0);
      set_lane(1, 1, 8'hA5, 0, 0, 1, 0, 0);
      tick(1);                                          // cycle 18
      check("drop_sync",   32'(ifa.altpcs_sync[0]), 32'h0);
      check("drop_data",   32'(ifa.altpcs_dataout[7:0]), 32'h0);
      check("drop_errdet", 32'(ifa.altpcs_errdetect[0]), 32'h1);
      tick(4);                                          // cycle 22
      check("requal_early", 32'(ifa.altpcs_sync[0]), 32'h0);
      tick(1);                                          // cycle 23
      check("requal", 32'(ifa.altpcs_sync[0]), 32'h1);
      set_lane(0, 1, 8'hBC, 1, 0, 0, 0, 0);
      tick(1);                                          // cycle 24
      set_lane(0, 1, 8'h50, 0, 0, 0, 0, 0);
      tick(1);                                          // cycle 25
      check("car_0", 32'(ifa.altpcs_carrierdetect[0]), 32'h1);
      set_lane(0, 1, 8'hFB, 1, 0, 0, 0, 0);
      tick(1);                                          // cycle 26
      check("car_1", 32'(ifa.altpcs_carrierdetect[0]), 32'h0);
      set_lane(0, 1, 8'h55, 0, 0, 0, 0, 0);
      tick(1);
      check("car_2", 32'(ifa.altpcs_carrierdetect[0]), 32'h0);
      tick(1);
      check("car_3", 32'(ifa.altpcs_carrierdetect[0]), 32'h1);
      tick(1);
      check("car_4", 32'(ifa.altpcs_carrierdetect[0]), 32'h1);

      // lane 1 and lane 2 traffic: comma, rate-match flags, /S/, sync loss
      set_lane(1, 1, 8'hBC, 1, 0, 0, 1, 0);
      set_lane(2, 1, 8'h3C, 0, 0, 1, 1, 0);
      tick(1);
      set_lane(1, 1, 8'h3C, 0, 0, 0, 0, 1);
      tick(1);
      set_lane(1, 1, 8'hFB, 1, 0, 0, 0, 0);
      tick(6);
      set_lane(1, 0, 8'h11, 0, 1, 0, 0, 0);
      tick(2);

      // error saturation and clear-over-increment on lane 0
      set_lane(0, 1, 8'h00, 0, 1, 0, 0, 0);
      tick(302);
      check("err_sat", 32'(err_cnt_a[7:0]), 32'hFF);
      set_lane(2, 0, 8'h77, 0, 1, 0, 0, 1);
      d_clr[0] = 1'b1;
      tick(1);
      check("clr_wins", 32'(err_cnt_a[7:0]), 32'h0);
      d_clr[0] = 1'b0;
      tick(1);
      check("after_clr", 32'(err_cnt_a[7:0]), 32'h1);
      tick(3);

      // asynchronous reset mid-stream
      reset_n = 1'b0;
      #1;
      check("arst_sync",     32'(ifa.altpcs_sync), 32'h0);
      check("arst_data",     32'(ifa.altpcs_dataout), 32'h0);
      check("arst_car",      32'(ifa.altpcs_carrierdetect), 32'h3);
      check("arst_errcnt_a", 32'(err_cnt_a), 32'h0);
      check("arst_errcnt_b", 32'(err_cnt_b), 32'h0);
      tick(1);
      reset_n = 1'b1;                                   // release, cycle R
      tick(5);
      check("post_rst_idle",  32'(ifa.altpcs_sync[0]), 32'h0);
      tick(1);
      check("post_rst_requal", 32'(ifa.altpcs_sync[0]), 32'h1);
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/altera_tse_gxb_aligned_rxsync_mc.md
ALTERA_TSE_GXB_ALIGNED_RXSYNC_MC -- requirements
Module: altera_tse_gxb_aligned_rxsync_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, meaning number of independent transceiver channels (1..8).
REQ-002 SHALL have parameter PIPE_DEPTH, default 2, meaning data-path register stages (1..4).
REQ-003 SHALL have parameter SYNC_DEBOUNCE, default 4, meaning consecutive alt_sync-high cycles required before sync is qualified (0..255).
REQ-004 SHALL have parameter ERR_CNT_W, default 16, meaning width of each per-channel error counter (8..32).
REQ-005 SHALL have parameter MASK_UNSYNCED, default 1, meaning: 1 forces idle values on unsynced output words; 0 passes them through.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port alt_dataout, input, 8*NUM_CH, decoded byte per channel; channel c occupies [8c+7:8c].
REQ-009 SHALL have ports alt_sync, alt_ctrldetect, alt_errdetect, alt_disperr, alt_patterndetect: input, NUM_CH each, per-channel GXB status flags.
REQ-010 SHALL have ports alt_rmfifodatadeleted and alt_rmfifodatainserted: input, NUM_CH each, rate-match FIFO events.
REQ-011 SHALL have port err_cnt_clr, input, NUM_CH, synchronous per-channel counter clear.
REQ-012 SHALL have port altpcs_dataout, output, 8*NUM_CH, aligned byte.
REQ-013 SHALL have ports altpcs_sync, altpcs_ctrldetect, altpcs_errdetect, altpcs_disperr: output, NUM_CH each, aligned with altpcs_dataout.
REQ-014 SHALL have ports altpcs_rmfifodatadeleted and altpcs_rmfifodatainserted: output, NUM_CH each, aligned with altpcs_dataout.
REQ-015 SHALL have port altpcs_carrierdetect, output, NUM_CH, carrier status (1 = carrier present).
REQ-016 SHALL have port err_cnt, output, ERR_CNT_W*NUM_CH, saturating code-group error count per channel.

Function
REQ-017 Channels SHALL be fully independent; no cross-channel state.
REQ-018 Debounce counter per channel:
- alt_sync=0 clears it to 0.
- alt_sync=1 increments it, saturating at SYNC_DEBOUNCE.
- qualified sync = alt_sync AND (counter == SYNC_DEBOUNCE), evaluated with the pre-increment counter value.
- SYNC_DEBOUNCE=0 qualifies in the same cycle.
REQ-019 Qualified sync SHALL drop in the same cycle alt_sync drops; loss is never debounced.
REQ-020 All inputs and the qualified sync SHALL traverse PIPE_DEPTH register stages, so altpcs_* equals the inputs from PIPE_DEPTH cycles earlier, with altpcs_sync equal to that word's qualified sync.
REQ-021 When MASK_UNSYNCED=1 and the output word's sync is 0, the output word SHALL be idle: dataout 0, disperr 1, errdetect 1, ctrldetect 0, rmfifo flags 0.
REQ-022 err_cnt increment: +1 per output word with altpcs_sync=1 and (errdetect OR disperr); saturate at all-ones; no wrap.
REQ-023 err_cnt_clr=1 SHALL set the counter to 0 on the next edge; clear wins over a simultaneous increment.
REQ-024 Carrier, per output word, registered, so it lags the altpcs_* word by 1 cycle, evaluated in priority order:
- sync=0 -> 1.
- ctrldetect=1 and data=8'hBC (comma /K28.5/) -> 0.
- ctrldetect=1 and data=8'hFB (/S/) -> 1.
- errdetect=1 -> 1 (false carrier).
- otherwise hold.
REQ-025 rmfifo flags SHALL pass unmodified on synced words; they have no effect on counters or carrier.

Reset
REQ-026 While reset_n=0, the block SHALL hold: debounce counters 0, all pipeline stages idle (values as REQ-021, sync 0), err_cnt 0, altpcs_carrierdetect 1.
REQ-027 Reset assertion mid-operation SHALL take effect immediately (asynchronous); after release, outputs remain idle for at least PIPE_DEPTH+SYNC_DEBOUNCE cycles.

Structure
REQ-028 A shared package SHALL hold the symbol constants K28_5=8'hBC and K27_7=8'hFB, plus the idle-word field values.
REQ-029 The per-channel logic SHALL be one sub-module, altera_tse_gxb_rxsync_lane, instantiated NUM_CH times by a generate loop.

Verification
REQ-030 NUM_CH=2, SYNC_DEBOUNCE=4, PIPE_DEPTH=2: raise ch0 alt_sync at cycle 10 -> altpcs_sync[0]=1 first at cycle 16; ch1 stays 0.
REQ-031 Drop alt_sync for 1 cycle after qualification -> altpcs_sync falls 2 cycles later, then needs 4 more high cycles to requalify; intervening words are idle (dataout 0, errdetect 1).
REQ-032 ERR_CNT_W=8: 300 synced words with errdetect=1 -> err_cnt=8'hFF; err_cnt_clr together with an error word -> 0.
REQ-033 Synced sequence BC(K), 50(D), FB(K), 55(D) -> carrierdetect 1,0,0,1,1 at the output side (1-cycle lag after reset value 1).
REQ-034 Assert reset_n=0 mid-stream for 1 cycle -> all outputs return to reset values the same cycle; err_cnt=0.
REQ-035 MASK_UNSYNCED=0, alt_sync=0, data 8'h5A -> altpcs_dataout=8'h5A after PIPE_DEPTH cycles, altpcs_sync=0, err_cnt unchanged.
